alu_hex_ctrl: RTL and testbench
===============================

ALU_HEX_CTRL -- requirements
Module: alu_hex_ctrl

Interface
REQ-001 Parameter DATA_W, default 32: operand/result width; SHALL be a multiple of 4 with NDIGITS*4 >= DATA_W.
REQ-002 Parameter NDIGITS, default 8: number of 7-segment digits driven.
REQ-003 Parameter DEB_CYC, default 16: number of consecutive stable samples required to accept a key level.
REQ-004 Parameter BLINK_W, default 22: blink counter width; blink phase is counter MSB.
REQ-005 Parameter LZ_BLANK, default 1: 1 blanks leading zero digits.
REQ-006 CLK  in  1  single clock, all state on rising edge.
REQ-007 RST  in  1  asynchronous, active-high reset.
REQ-008 key_n  in  3  raw active-low keys: [0] load A, [1] load B, [2] execute.
REQ-009 din  in  DATA_W  operand entry value.
REQ-010 op_in  in  4  ALU opcode sampled on execute.
REQ-011 alu_a, alu_b  out  DATA_W  registered operands to external ALU.
REQ-012 alu_op  out  4  registered opcode to external ALU.
REQ-013 alu_o  in  DATA_W; alu_neg, alu_of, alu_zero  in  1 each: ALU result and flags.
REQ-014 hex  out  NDIGITS*7  registered active-low segments, digit i at [7i+6:7i], digit 0 least significant nibble.
REQ-015 flags  out  3  latched {zero, of, neg}.
REQ-016 state  out  2  FSM state: IDLE=0, EXEC=1, SHOW=2.

Function
REQ-017 Each key SHALL have an independent debouncer: the debounced level changes only after DEB_CYC consecutive identical raw samples.
REQ-018 A press pulse SHALL be one cycle, asserted on the cycle the debounced level goes from released to pressed; holding a key produces no further pulses.
REQ-019 A load-A pulse SHALL capture din into alu_a on that edge; a load-B pulse likewise into alu_b; both in one cycle capture both.
REQ-020 Load pulses SHALL be accepted in any state; a load pulse in SHOW SHALL move state to IDLE.
REQ-021 An execute pulse in IDLE or SHOW with no load pulse in the same cycle SHALL latch op_in into alu_op and move state to EXEC.
REQ-022 An execute pulse coinciding with any load pulse SHALL be ignored (load wins).
REQ-023 EXEC SHALL last exactly one cycle; on its exit edge result <= alu_o, flags <= {alu_zero, alu_of, alu_neg}, state <= SHOW.
REQ-024 Key pulses arriving while in EXEC SHALL be ignored; no queueing.
REQ-025 Display source SHALL be din in IDLE and EXEC, result in SHOW.
REQ-026 hex SHALL be registered: one cycle from source value to segments.
REQ-027 Nibble encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, B=0000011, C=0100111, D=0100001, E=0000110, F=0001110; blank=1111111.
REQ-028 Digits with index >= DATA_W/4 SHALL be blank.
REQ-029 With LZ_BLANK=1, zero digits above the most significant nonzero digit SHALL be blank; digit 0 always displayed (value 0 shows single "0").
REQ-030 Free-running blink counter of BLINK_W bits SHALL wrap from all-ones to 0.
REQ-031 In SHOW with flags.of=1 all digits SHALL be blank while counter MSB=1, normal otherwise; no blinking in any other case.

Reset
REQ-032 On RST assertion, immediately and independent of CLK: alu_a, alu_b, result, alu_op, flags, blink counter = 0; state = IDLE; debouncers = released, counts 0; hex = all blank.
REQ-033 RST asserted during EXEC SHALL abort without latching result or flags.
REQ-034 After RST release, keys held pressed SHALL produce no pulse until released and re-pressed.

Verification (DATA_W=32, NDIGITS=8, DEB_CYC=4, BLINK_W=4)
REQ-035 key_n[0] low 3 cycles then high, din=0x1234 -> no capture, alu_a stays 0; low 4 cycles -> alu_a=0x00001234, exactly one capture.
REQ-036 Load A=5, B=7, op_in=ADD, execute -> state IDLE->EXEC->SHOW, ALU returns 0xC, hex shows blank x7 then "C", flags=000.
REQ-037 ALU returns 0x80000000 with of=1 -> flags=010, hex "80000000" blanked for 8 cycles every 16.
REQ-038 Load-B and execute pulses in the same cycle -> alu_b captured, state stays IDLE, alu_op unchanged.
REQ-039 RST pulse mid-EXEC -> state IDLE, result/flags 0, hex all blank one cycle, then din displayed.

Source files
------------

// File: rtl/alu_hex_ctrl_if.sv
// Bus bundle between alu_hex_ctrl and its environment (keys, operand entry, external ALU, display).
interface alu_hex_ctrl_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NDIGITS = 8
);
    logic [2:0]           key_n;
    logic [DATA_W-1:0]    din;
    logic [3:0]           op_in;
    logic [DATA_W-1:0]    alu_a;
    logic [DATA_W-1:0]    alu_b;
    logic [3:0]           alu_op;
    logic [DATA_W-1:0]    alu_o;
    logic                 alu_neg;
    logic                 alu_of;
    logic                 alu_zero;
    logic [NDIGITS*7-1:0] hex;
    logic [2:0]           flags;
    logic [1:0]           state;

    // Environment side: drives keys, operand entry and ALU result.
    modport master (
        output key_n, din, op_in, alu_o, alu_neg, alu_of, alu_zero,
        input  alu_a, alu_b, alu_op, hex, flags, state
    );

    // Controller side.
    modport slave (
        input  key_n, din, op_in, alu_o, alu_neg, alu_of, alu_zero,
        output alu_a, alu_b, alu_op, hex, flags, state
    );
endinterface

// File: rtl/alu_hex_ctrl.sv
// Key-driven operand/opcode controller for an external ALU with a 7-segment hex readout.
module alu_hex_ctrl #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NDIGITS  = 8,
    parameter int unsigned DEB_CYC  = 16,
    parameter int unsigned BLINK_W  = 22,
    parameter int unsigned LZ_BLANK = 1
) (
    input  logic          clk,
    input  logic          rst,
    alu_hex_ctrl_if.slave bus
);

    localparam int unsigned NKEY     = 3;
    localparam int unsigned DIG_USED = DATA_W / 4;
    localparam int unsigned CNT_W    = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam int unsigned HEX_W    = NDIGITS * 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_SHOW = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [NKEY-1:0]     r_sync1;
    logic [NKEY-1:0]     r_sync2;
    logic [NKEY-1:0]     w_key_raw;
    logic [NKEY-1:0]     r_deb_lvl;
    logic [CNT_W-1:0]    r_deb_cnt [NKEY];
    logic [NKEY-1:0]     r_armed;
    logic [NKEY-1:0]     r_press;

    logic                w_load_a;
    logic                w_load_b;
    logic                w_exec;
    logic                w_any_load;
    logic                w_cap_a;
    logic                w_cap_b;
    logic                w_cap_op;
    logic                w_cap_res;

    logic [DATA_W-1:0]   r_alu_a;
    logic [DATA_W-1:0]   r_alu_b;
    logic [3:0]          r_alu_op;
    logic [DATA_W-1:0]   r_result;
    logic [2:0]          r_flags;
    logic [BLINK_W-1:0]  r_blink;
    logic [HEX_W-1:0]    r_hex;

    logic [DATA_W-1:0]   w_src;
    logic                w_blank_all;
    int unsigned         w_msd;
    logic [HEX_W-1:0]    w_hex_nxt;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0:    seg7 = 7'b1000000;
            4'h1:    seg7 = 7'b1111001;
            4'h2:    seg7 = 7'b0100100;
            4'h3:    seg7 = 7'b0110000;
            4'h4:    seg7 = 7'b0011001;
            4'h5:    seg7 = 7'b0010010;
            4'h6:    seg7 = 7'b0000010;
            4'h7:    seg7 = 7'b1111000;
            4'h8:    seg7 = 7'b0000000;
            4'h9:    seg7 = 7'b0010000;
            4'hA:    seg7 = 7'b0001000;
            4'hB:    seg7 = 7'b0000011;
            4'hC:    seg7 = 7'b0100111;
            4'hD:    seg7 = 7'b0100001;
            4'hE:    seg7 = 7'b0000110;
            4'hF:    seg7 = 7'b0001110;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Raw keys as active-high "pressed" after the synchronizer.
    assign w_key_raw = ~r_sync2;

    // Synchronize, debounce and edge-detect each key. Synchronizer resets to the
    // pressed level so a key held through reset never looks released and never arms.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_deb_lvl <= '0;
            r_armed   <= '0;
            r_press   <= '0;
            for (int k = 0; k < NKEY; k++) begin
                r_deb_cnt[k] <= '0;
            end
        end else begin
            r_sync1 <= bus.key_n;
            r_sync2 <= r_sync1;
            for (int k = 0; k < NKEY; k++) begin
                r_press[k] <= 1'b0;
                if (w_key_raw[k] == r_deb_lvl[k]) begin
                    r_deb_cnt[k] <= '0;
                    if (!w_key_raw[k]) begin
                        r_armed[k] <= 1'b1;
                    end
                end else if (r_deb_cnt[k] == CNT_W'(DEB_CYC - 1)) begin
                    r_deb_lvl[k] <= w_key_raw[k];
                    r_deb_cnt[k] <= '0;
                    r_press[k]   <= w_key_raw[k] & r_armed[k];
                end else begin
                    r_deb_cnt[k] <= r_deb_cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    assign w_load_a   = r_press[0];
    assign w_load_b   = r_press[1];
    assign w_exec     = r_press[2];
    assign w_any_load = w_load_a | w_load_b;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and capture enables; EXEC is a one-cycle slot that ignores keys.
    always_comb begin
        w_state_nxt = r_state;
        w_cap_a     = 1'b0;
        w_cap_b     = 1'b0;
        w_cap_op    = 1'b0;
        w_cap_res   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cap_a = w_load_a;
                w_cap_b = w_load_b;
                if (w_exec && !w_any_load) begin
                    w_cap_op    = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_cap_res   = 1'b1;
                w_state_nxt = ST_SHOW;
            end
            ST_SHOW: begin
                w_cap_a = w_load_a;
                w_cap_b = w_load_b;
                if (w_any_load) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_exec) begin
                    w_cap_op    = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand, opcode, result and flag registers plus the free-running blink counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= '0;
            r_result <= '0;
            r_flags  <= '0;
            r_blink  <= '0;
        end else begin
            r_blink <= r_blink + BLINK_W'(1);
            if (w_cap_a) begin
                r_alu_a <= bus.din;
            end
            if (w_cap_b) begin
                r_alu_b <= bus.din;
            end
            if (w_cap_op) begin
                r_alu_op <= bus.op_in;
            end
            if (w_cap_res) begin
                r_result <= bus.alu_o;
                r_flags  <= {bus.alu_zero, bus.alu_of, bus.alu_neg};
            end
        end
    end

    assign w_src       = (r_state == ST_SHOW) ? r_result : bus.din;
    assign w_blank_all = (r_state == ST_SHOW) && r_flags[1] && r_blink[BLINK_W-1];

    // Segment pattern for the current display source, with leading-zero and overflow-blink blanking.
    always_comb begin
        w_msd     = 0;
        w_hex_nxt = '1;
        for (int unsigned i = 0; i < DIG_USED; i++) begin
            if (w_src[4*i +: 4] != 4'd0) begin
                w_msd = i;
            end
        end
        if (!w_blank_all) begin
            for (int unsigned i = 0; i < DIG_USED; i++) begin
                if ((LZ_BLANK == 0) || (i <= w_msd)) begin
                    w_hex_nxt[7*i +: 7] = seg7(w_src[4*i +: 4]);
                end
            end
        end
    end

    // Registered segment drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hex <= '1;
        end else begin
            r_hex <= w_hex_nxt;
        end
    end

    assign bus.alu_a  = r_alu_a;
    assign bus.alu_b  = r_alu_b;
    assign bus.alu_op = r_alu_op;
    assign bus.hex    = r_hex;
    assign bus.flags  = r_flags;
    assign bus.state  = r_state;

endmodule

// File: tb/tb_alu_hex_ctrl.sv
// Self-checking bench for alu_hex_ctrl: directed scenarios plus randomized load/execute traffic.
module tb_alu_hex_ctrl;

    localparam int unsigned DW  = 32;
    localparam int unsigned ND  = 8;
    localparam int unsigned DEB = 4;
    localparam int unsigned BW  = 4;

    // Segment patterns, nibble F in the top slot down to nibble 0 in the bottom slot.
    localparam logic [111:0] SEG_TAB = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b0100111,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };
    localparam logic [55:0] ALL_BLANK = {56{1'b1}};

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  key_n;
    logic [31:0] din;
    logic [3:0]  op_in;
    logic [31:0] alu_o;
    logic        alu_neg, alu_of, alu_zero;

    int checks = 0;
    int errors = 0;
    int tb_cyc;

    logic [31:0] m_a, m_b, m_res;
    logic [3:0]  m_op;
    logic [2:0]  m_flags;
    logic [1:0]  m_state;

    always #5 clk = ~clk;

    alu_hex_ctrl_if #(.DATA_W(DW), .NDIGITS(ND)) bus ();

    assign bus.key_n    = key_n;
    assign bus.din      = din;
    assign bus.op_in    = op_in;
    assign bus.alu_o    = alu_o;
    assign bus.alu_neg  = alu_neg;
    assign bus.alu_of   = alu_of;
    assign bus.alu_zero = alu_zero;

    alu_hex_ctrl #(
        .DATA_W(DW), .NDIGITS(ND), .DEB_CYC(DEB), .BLINK_W(BW), .LZ_BLANK(1)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock edges since the last reset release; sets the blink phase reference.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_cyc <= 0;
        else     tb_cyc <= tb_cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Display a value as hex with leading zeros blanked (digit 0 always lit).
    function automatic logic [55:0] ref_hex(input logic [31:0] v, input bit blank_all);
        logic [55:0] r;
        int nsig;
        int d;
        r = ALL_BLANK;
        if (blank_all) return r;
        nsig = 1;
        for (int k = 1; k < 8; k++) if ((v >> (4*k)) != 0) nsig = k + 1;
        for (int i = 0; i < nsig; i++) begin
            d = int'((v >> (4*i)) & 32'hF);
            r[7*i +: 7] = SEG_TAB[7*d +: 7];
        end
        return r;
    endfunction

    // Result display: with overflow, dark during the upper half of each 16-cycle blink period.
    function automatic logic [55:0] exp_show_hex(input logic [31:0] v, input logic of);
        return ref_hex(v, of && (((tb_cyc - 1) % 16) >= 8));
    endfunction

    task automatic press(input logic [2:0] mask, input int n);
        key_n = ~mask;
        repeat (n) @(negedge clk);
        key_n = 3'b111;
        repeat (DEB + 8) @(negedge clk);
    endtask

    task automatic check_all(input string tag);
        check({tag, ":state"}, 64'(bus.state), 64'(m_state));
        check({tag, ":a"}, 64'(bus.alu_a), 64'(m_a));
        check({tag, ":b"}, 64'(bus.alu_b), 64'(m_b));
        check({tag, ":op"}, 64'(bus.alu_op), 64'(m_op));
        check({tag, ":flags"}, 64'(bus.flags), 64'(m_flags));
        if (m_state == 2'd2) check({tag, ":hex"}, 64'(bus.hex), 64'(exp_show_hex(m_res, m_flags[1])));
        else                 check({tag, ":hex"}, 64'(bus.hex), 64'(ref_hex(din, 1'b0)));
    endtask

    task automatic model_reset();
        m_a = '0; m_b = '0; m_res = '0; m_op = '0; m_flags = '0; m_state = 2'd0;
    endtask

    initial begin
        int exec_len;
        int after_exec;
        int blanks;
        int found;
        int sel;
        logic [2:0] f;

        rst = 1'b1; key_n = 3'b111; din = '0; op_in = '0;
        alu_o = '0; alu_neg = 1'b0; alu_of = 1'b0; alu_zero = 1'b0;
        model_reset();
        #2;
        check("rst_hex", 64'(bus.hex), 64'(ALL_BLANK));
        check("rst_state", 64'(bus.state), 64'd0);
        check("rst_a", 64'(bus.alu_a), 64'd0);
        check("rst_flags", 64'(bus.flags), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_all("idle0");
        check("hex_zero", 64'(bus.hex), 64'({{49{1'b1}}, 7'b1000000}));

        // Debounce threshold: 3 samples rejected, 4 accepted.
        din = 32'h1234;
        press(3'b001, 3);
        check("deb_short", 64'(bus.alu_a), 64'd0);
        press(3'b001, 4);
        m_a = 32'h1234;
        check("deb_exact", 64'(bus.alu_a), 64'h1234);

        // Held key gives a single capture.
        din = 32'hABCD;
        key_n = 3'b110;
        repeat (12) @(negedge clk);
        din = 32'h5555;
        repeat (10) @(negedge clk);
        key_n = 3'b111;
        repeat (DEB + 8) @(negedge clk);
        m_a = 32'hABCD;
        check_all("hold");

        // 5 + 7 through IDLE -> EXEC -> SHOW.
        din = 32'd5; press(3'b001, 6); m_a = 32'd5;
        din = 32'd7; press(3'b010, 6); m_b = 32'd7;
        check_all("ops");
        op_in = 4'h0; alu_o = m_a + m_b;
        exec_len = 0; after_exec = -1;
        key_n = 3'b011;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (bus.state == 2'd1) exec_len++;
            else if (exec_len > 0 && after_exec < 0) after_exec = int'(bus.state);
        end
        key_n = 3'b111;
        repeat (DEB + 8) @(negedge clk);
        check("exec_len", 64'(exec_len), 64'd1);
        check("exec_next", 64'(after_exec), 64'd2);
        m_state = 2'd2; m_res = 32'hC; m_flags = 3'b000; m_op = 4'h0;
        check_all("add");
        check("hexC", 64'(bus.hex), 64'({{49{1'b1}}, 7'b0100111}));

        // Overflow result blinks with the 16-cycle counter.
        alu_o = 32'h8000_0000; alu_of = 1'b1; op_in = 4'h3;
        press(3'b100, 6);
        m_res = alu_o; m_flags = 3'b010; m_op = 4'h3;
        check("of_flags", 64'(bus.flags), 64'b010);
        blanks = 0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (((tb_cyc - 1) % 16) >= 8) begin
                blanks++;
                check("blink_off", 64'(bus.hex), 64'(ALL_BLANK));
            end else begin
                check("blink_on", 64'(bus.hex), 64'({7'b0000000, {7{7'b1000000}}}));
            end
        end
        check("blink_count", 64'(blanks), 64'd16);
        alu_of = 1'b0;

        // Load in SHOW returns to IDLE; load with execute keeps IDLE and opcode.
        din = 32'h0000_0042; press(3'b001, 6); m_a = din; m_state = 2'd0;
        check_all("show_load");
        din = 32'h77; op_in = 4'h9;
        press(3'b110, 6);
        m_b = 32'h77;
        check_all("load_wins");

        // Randomized loads and executes.
        for (int it = 0; it < 24; it++) begin
            sel = int'($urandom_range(0, 3));
            din = $urandom >> $urandom_range(0, 31);
            if (sel == 3) begin
                op_in = 4'($urandom_range(0, 15));
                alu_o = $urandom >> $urandom_range(0, 31);
                f = 3'($urandom_range(0, 7));
                {alu_zero, alu_of, alu_neg} = f;
                press(3'b100, 6);
                m_op = op_in; m_res = alu_o; m_flags = f; m_state = 2'd2;
            end else begin
                press((sel == 0) ? 3'b001 : (sel == 1) ? 3'b010 : 3'b011, 6);
                if (sel != 1) m_a = din;
                if (sel != 0) m_b = din;
                m_state = 2'd0;
            end
            check_all($sformatf("rnd%0d", it));
        end
        alu_zero = 1'b0; alu_of = 1'b0; alu_neg = 1'b0;

        // Reset during EXEC, with the execute key held through reset.
        din = 32'h0000_BEEF; op_in = 4'h5; alu_o = 32'h1111; alu_zero = 1'b1; alu_neg = 1'b1;
        found = 0;
        key_n = 3'b011;
        for (int c = 0; c < 20 && found == 0; c++) begin
            @(negedge clk);
            if (bus.state == 2'd1) found = 1;
        end
        check("exec_seen", 64'(found), 64'd1);
        rst = 1'b1;
        #1;
        model_reset();
        check("abort_state", 64'(bus.state), 64'd0);
        check("abort_flags", 64'(bus.flags), 64'd0);
        check("abort_hex", 64'(bus.hex), 64'(ALL_BLANK));
        @(negedge clk);
        rst = 1'b0;
        check("abort_hex_hold", 64'(bus.hex), 64'(ALL_BLANK));
        @(negedge clk);
        check("post_rst_din", 64'(bus.hex), 64'(ref_hex(din, 1'b0)));
        repeat (20) @(negedge clk);
        check_all("held_no_pulse");
        key_n = 3'b111;
        repeat (DEB + 8) @(negedge clk);
        check_all("released");
        press(3'b100, 6);
        m_op = 4'h5; m_res = 32'h1111; m_flags = 3'b101; m_state = 2'd2;
        check_all("repress");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
